reset_sync_gen: RTL
===================

// Module: reset_sync_gen
// PURPOSE
//  Reset source for the async-reset register fabric. Takes a raw external reset
//  and drives rst_out into the rst pins of downstream async-reset registers:
//  - rst_out asserts asynchronously.
//  - rst_out deasserts synchronously to clk, after a synchronizer and a stretch counter.
//  - Optionally accepts a software reset request through a 4-phase handshake.
// PARAMETERS
//  SYNC_STAGES     3   synchronizer flops on rst deassertion; legal 2..8
//  STRETCH_CYCLES  16  extra clk cycles rst_out is held after sync; legal 0..255
//  CNT_W           8   stretch counter width; must hold STRETCH_CYCLES
// PORTS
//  clk         in   1  clock
//  rst         in   1  reset, asynchronous, active-high (raw external reset)
//  rst_out     out  1  generated reset: async assert, clk-sync deassert
//  rst_done    out  1  one-cycle pulse on the first clk cycle with rst_out low
//  sw_rst_req  in   1  software reset request, level (ASYNC_RESET_SW_REQ_EN only)
//  sw_rst_ack  out  1  software reset acknowledge (ASYNC_RESET_SW_REQ_EN only)
// BEHAVIOUR
//  Reset values while rst=1:
//  - rst_out=1 immediately, with no clk needed.
//  - rst_done=0, sw_rst_ack=0, sync chain=0, counter=0, state=SYNC.
//  States:
//  - SYNC: shift 1 into the chain on each clk edge. When the last stage is 1,
//    go to STRETCH, or go to RUN if STRETCH_CYCLES=0.
//  - STRETCH: counter increments each edge. At count==STRETCH_CYCLES-1, go to
//    RUN and clear the counter.
//  - RUN: rst_out=0. rst_done=1 for exactly the first cycle in RUN.
//  - SW_HOLD (macro only): rst_out=1, asserted synchronously. Hold for
//    max(STRETCH_CYCLES,1) cycles, then go to SW_ACK.
//  - SW_ACK (macro only): rst_out=0, sw_rst_ack=1, rst_done pulses on entry.
//    Return to RUN on the edge after sw_rst_req is sampled 0.
//  Deassert latency:
//  - rst_out falls on exactly the (SYNC_STAGES+STRETCH_CYCLES)-th rising clk
//    edge after rst falls. rst_out is never low for a partial cycle.
//  rst re-asserted mid-sequence, in any state:
//  - Async return to SYNC. Chain and counter cleared, sw_rst_ack=0.
//  - The full latency restarts from the next rst fall.
//  - A rst pulse shorter than one clk period still restarts the full sequence.
//  Software request:
//  - sw_rst_req is sampled only in RUN; ignored in SYNC/STRETCH/SW_HOLD.
//  - A request dropped during SW_HOLD does not abort the hold. SW_ACK is still
//    entered, sw_rst_ack is high for one cycle, then the block returns to RUN.
//  - A request held high in SW_ACK gives no new reset; the requester must drop
//    req before re-requesting.
//  Width rule:
//  - Counter compares at CNT_W bits.
//  - STRETCH_CYCLES >= 2**CNT_W is an elaboration error (generate-time $error).
//  - No wrap-around is allowed.
//  rst_done is a registered output, asynchronously cleared by rst.
// CONFIGURATION
//  ASYNC_RESET_SW_REQ_EN defined:
//  - sw_rst_req/sw_rst_ack ports and the SW_HOLD/SW_ACK states exist.
//  ASYNC_RESET_SW_REQ_EN undefined:
//  - Ports, states and logic are omitted; RUN is terminal until rst.
//  - Timing of all other outputs is identical in both builds.
// TESTING (SYNC_STAGES=3, STRETCH_CYCLES=4 unless noted)
//  1. Power-on:
//     rst=1 for 5 cycles, released mid-cycle -> rst_out=1 throughout; falls on
//     edge 7 after release; rst_done=1 for that one cycle only.
//  2. Async assert:
//     rst pulses 1 between edges while in RUN -> rst_out rises within the same
//     cycle (no edge); re-release gives 7-edge latency again.
//  3. Mid-sequence reset:
//     rst re-asserted on edge 5 (in STRETCH) -> counter clears; rst_out stays 1;
//     7 edges counted from second release.
//  4. STRETCH_CYCLES=0:
//     release -> rst_out falls on edge 3, rst_done pulses once.
//  5. SW request (macro):
//     sw_rst_req=1 in RUN -> rst_out=1 next cycle for 4 cycles; then
//     sw_rst_ack=1; req dropped -> ack=0 the next cycle; rst_done pulses once.
//  6. SW request edge cases (macro):
//     req held across SW_ACK -> no second reset.
//     req dropped during SW_HOLD -> ack high exactly 1 cycle.
//     rst during SW_HOLD -> ack stays 0, full power-on sequence.

Source files
------------

// File: rtl/reset_sync_gen.sv
// Reset generator: asynchronous assert, clk-synchronous deassert after a synchronizer and a stretch counter.
// Optional software reset handshake is compiled in when ASYNC_RESET_SW_REQ_EN is defined.
`timescale 1ns/1ps
module reset_sync_gen #(
    parameter int SYNC_STAGES    = 3,
    parameter int STRETCH_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst,
    output logic rst_out,
    output logic rst_done
`ifdef ASYNC_RESET_SW_REQ_EN
    ,
    input  logic sw_rst_req,
    output logic sw_rst_ack
`endif
);

    localparam logic [CNT_W-1:0] STRETCH_LAST =
        CNT_W'((STRETCH_CYCLES > 0) ? STRETCH_CYCLES - 1 : 0);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 8) begin : g_bad_sync
            $error("reset_sync_gen: SYNC_STAGES must be in 2..8");
        end
        if (STRETCH_CYCLES < 0 || STRETCH_CYCLES > 255 ||
            STRETCH_CYCLES >= (1 << CNT_W)) begin : g_bad_stretch
            $error("reset_sync_gen: STRETCH_CYCLES out of range for CNT_W");
        end
    endgenerate

`ifdef ASYNC_RESET_SW_REQ_EN
    localparam int               HOLD_CYCLES = (STRETCH_CYCLES > 0) ? STRETCH_CYCLES : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_SYNC    = 3'd0,
        ST_STRETCH = 3'd1,
        ST_RUN     = 3'd2,
        ST_SW_HOLD = 3'd3,
        ST_SW_ACK  = 3'd4
    } state_t;

    logic r_sw_ack;
`else
    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RUN     = 2'd2
    } state_t;
`endif

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_rst_out;
    logic                   r_rst_done;

    // The chain flop about to become full (index SYNC_STAGES-2) triggers the
    // transition, so the last stage and the state change land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_SYNC;
            r_sync     <= '0;
            r_cnt      <= '0;
            r_rst_out  <= 1'b1;
            r_rst_done <= 1'b0;
`ifdef ASYNC_RESET_SW_REQ_EN
            r_sw_ack   <= 1'b0;
`endif
        end else begin
            r_rst_done <= 1'b0;
            case (r_state)
                ST_SYNC: begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
                    if (r_sync[SYNC_STAGES-2]) begin
                        if (STRETCH_CYCLES == 0) begin
                            r_state    <= ST_RUN;
                            r_rst_out  <= 1'b0;
                            r_rst_done <= 1'b1;
                        end else begin
                            r_state <= ST_STRETCH;
                        end
                    end
                end
                ST_STRETCH: begin
                    if (r_sync[SYNC_STAGES-1]) begin
                        if (r_cnt == STRETCH_LAST) begin
                            r_cnt      <= '0;
                            r_state    <= ST_RUN;
                            r_rst_out  <= 1'b0;
                            r_rst_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
`ifdef ASYNC_RESET_SW_REQ_EN
                    if (sw_rst_req) begin
                        r_state   <= ST_SW_HOLD;
                        r_rst_out <= 1'b1;
                        r_cnt     <= '0;
                    end
`endif
                end
`ifdef ASYNC_RESET_SW_REQ_EN
                // Hold runs to completion even if the request drops meanwhile.
                ST_SW_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt      <= '0;
                        r_state    <= ST_SW_ACK;
                        r_rst_out  <= 1'b0;
                        r_sw_ack   <= 1'b1;
                        r_rst_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SW_ACK: begin
                    if (!sw_rst_req) begin
                        r_state  <= ST_RUN;
                        r_sw_ack <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state   <= ST_SYNC;
                    r_rst_out <= 1'b1;
                end
            endcase
        end
    end

    assign rst_out  = r_rst_out;
    assign rst_done = r_rst_done;
`ifdef ASYNC_RESET_SW_REQ_EN
    assign sw_rst_ack = r_sw_ack;
`endif

endmodule
